// File: rtl/axis_hdr_insert_queued.sv
// AXI-Stream header inserter: per-packet headers are queued, prepended to each payload
// packet, and the combined byte stream is repacked into full output beats.
module axis_hdr_insert_queued #(
    parameter int DATA_WD   = 32,
    parameter int HDR_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        valid_insert,
    output logic                        ready_insert,
    input  logic [DATA_WD-1:0]          data_insert,
    input  logic [DATA_WD/8-1:0]        keep_insert,
    input  logic [$clog2(DATA_WD/8):0]  byte_insert_cnt,
    input  logic                        valid_in,
    output logic                        ready_in,
    input  logic                        last_in,
    input  logic [DATA_WD-1:0]          data_in,
    input  logic [DATA_WD/8-1:0]        keep_in,
    output logic                        valid_out,
    input  logic                        ready_out,
    output logic                        last_out,
    output logic [DATA_WD-1:0]          data_out,
    output logic [DATA_WD/8-1:0]        keep_out,
    output logic [$clog2(HDR_DEPTH):0]  hdr_count
);
    localparam int DATA_BYTE_WD = DATA_WD / 8;
    localparam int CNT_WD       = $clog2(DATA_BYTE_WD) + 1;
    localparam int QCNT_WD      = $clog2(HDR_DEPTH) + 1;
    localparam int PTR_WD       = $clog2(HDR_DEPTH);
    localparam int TOT_WD       = CNT_WD + 1;
    localparam logic [CNT_WD-1:0]  FULL_CNT = CNT_WD'(DATA_BYTE_WD);
    localparam logic [TOT_WD-1:0]  FULL_TOT = TOT_WD'(DATA_BYTE_WD);
    localparam logic [QCNT_WD-1:0] Q_FULL   = QCNT_WD'(HDR_DEPTH);

    typedef enum logic [1:0] {IDLE = 2'd0, STREAM = 2'd1, FLUSH = 2'd2} state_t;

    function automatic logic [DATA_BYTE_WD-1:0] lead_mask(input logic [TOT_WD-1:0] n);
        logic [DATA_BYTE_WD-1:0] m;
        m = {DATA_BYTE_WD{1'b0}};
        for (int i = 0; i < DATA_BYTE_WD; i++) begin
            m[DATA_BYTE_WD-1-i] = (TOT_WD'(i) < n);
        end
        return m;
    endfunction

    function automatic logic [DATA_WD-1:0] byte_expand(input logic [DATA_BYTE_WD-1:0] k);
        logic [DATA_WD-1:0] m;
        m = {DATA_WD{1'b0}};
        for (int i = 0; i < DATA_BYTE_WD; i++) begin
            m[i*8 +: 8] = {8{k[i]}};
        end
        return m;
    endfunction

    function automatic logic [CNT_WD-1:0] ones_cnt(input logic [DATA_BYTE_WD-1:0] k);
        logic [CNT_WD-1:0] n;
        n = {CNT_WD{1'b0}};
        for (int i = 0; i < DATA_BYTE_WD; i++) begin
            n = n + {{(CNT_WD-1){1'b0}}, k[i]};
        end
        return n;
    endfunction

    state_t                 state_r, state_n;
    logic                   first_r, first_n;
    logic [DATA_WD-1:0]     carry_r, carry_n;
    logic [CNT_WD-1:0]      carry_cnt_r, carry_cnt_n;
    logic [QCNT_WD-1:0]     count_r;
    logic [PTR_WD-1:0]      wr_ptr_r, rd_ptr_r;
    logic [DATA_WD-1:0]     hdr_data_r [HDR_DEPTH];
    logic [CNT_WD-1:0]      hdr_cnt_r  [HDR_DEPTH];

    logic                   push_s, pop_s, accept_s, out_free_s, ready_in_s;
    logic                   load_s, ld_last_s;
    logic [DATA_WD-1:0]     ld_data_s;
    logic [DATA_BYTE_WD-1:0] ld_keep_s;
    logic [CNT_WD-1:0]      hdr_cnt_s, src_cnt_s, beat_cnt_s, rem_cnt_s;
    logic [DATA_WD-1:0]     hdr_word_s, src_data_s, beat_data_s;
    logic [2*DATA_WD-1:0]   wide_s;
    logic [TOT_WD-1:0]      total_s;
    logic [QCNT_WD-1:0]     left_s;
    logic                   unused_s;

    // keep_insert is advisory only; the byte count decides which header bytes are used.
    assign unused_s     = ^keep_insert;
    assign ready_insert = (count_r != Q_FULL);
    assign hdr_count    = count_r;
    assign ready_in     = ready_in_s;
    assign out_free_s   = !valid_out || ready_out;
    assign push_s       = valid_insert && ready_insert;
    assign accept_s     = valid_in && ready_in_s;
    assign pop_s        = accept_s && first_r;
    assign left_s       = count_r - {{(QCNT_WD-1){1'b0}}, pop_s};

    // Clamp the header length and left-align its bytes so header byte 0 sits at the MSB.
    always_comb begin
        hdr_cnt_s  = (byte_insert_cnt > FULL_CNT) ? FULL_CNT : byte_insert_cnt;
        hdr_word_s = data_insert << {(FULL_CNT - hdr_cnt_s), 3'b000};
    end

    // Concatenate carried bytes (or the fresh header) with the masked payload beat.
    always_comb begin
        src_data_s  = first_r ? hdr_data_r[rd_ptr_r] : carry_r;
        src_cnt_s   = first_r ? hdr_cnt_r[rd_ptr_r] : carry_cnt_r;
        beat_cnt_s  = last_in ? ones_cnt(keep_in) : FULL_CNT;
        beat_data_s = last_in ? (data_in & byte_expand(keep_in)) : data_in;
        wide_s      = {src_data_s, {DATA_WD{1'b0}}}
                    | ({beat_data_s, {DATA_WD{1'b0}}} >> {src_cnt_s, 3'b000});
        total_s     = {1'b0, src_cnt_s} + {1'b0, beat_cnt_s};
        rem_cnt_s   = CNT_WD'(total_s - FULL_TOT);
    end

    // Next-state, carry update and output-beat selection.
    always_comb begin
        state_n     = state_r;
        first_n     = first_r;
        carry_n     = carry_r;
        carry_cnt_n = carry_cnt_r;
        ready_in_s  = 1'b0;
        load_s      = 1'b0;
        ld_data_s   = {DATA_WD{1'b0}};
        ld_keep_s   = {DATA_BYTE_WD{1'b0}};
        ld_last_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (count_r != {QCNT_WD{1'b0}}) begin
                    state_n = STREAM;
                    first_n = 1'b1;
                end else begin
                    state_n = IDLE;
                end
            end
            STREAM: begin
                ready_in_s = out_free_s;
                if (accept_s) begin
                    load_s    = 1'b1;
                    first_n   = 1'b0;
                    ld_data_s = wide_s[2*DATA_WD-1 -: DATA_WD];
                    if (total_s > FULL_TOT) begin
                        carry_n     = wide_s[DATA_WD-1:0];
                        carry_cnt_n = rem_cnt_s;
                    end else begin
                        carry_n     = {DATA_WD{1'b0}};
                        carry_cnt_n = {CNT_WD{1'b0}};
                    end
                    if (last_in && (total_s > FULL_TOT)) begin
                        ld_keep_s = {DATA_BYTE_WD{1'b1}};
                        state_n   = FLUSH;
                    end else if (last_in) begin
                        ld_keep_s = lead_mask(total_s);
                        ld_last_s = 1'b1;
                        // Chain straight into the next packet when its header is waiting.
                        if (left_s != {QCNT_WD{1'b0}}) begin
                            state_n = STREAM;
                            first_n = 1'b1;
                        end else begin
                            state_n = IDLE;
                        end
                    end else begin
                        ld_keep_s = {DATA_BYTE_WD{1'b1}};
                    end
                end else begin
                    state_n = STREAM;
                end
            end
            FLUSH: begin
                if (out_free_s) begin
                    load_s      = 1'b1;
                    ld_data_s   = carry_r;
                    ld_keep_s   = lead_mask({1'b0, carry_cnt_r});
                    ld_last_s   = 1'b1;
                    carry_n     = {DATA_WD{1'b0}};
                    carry_cnt_n = {CNT_WD{1'b0}};
                    if (count_r != {QCNT_WD{1'b0}}) begin
                        state_n = STREAM;
                        first_n = 1'b1;
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    state_n = FLUSH;
                end
            end
            default: begin
                state_n = IDLE;
                first_n = 1'b0;
            end
        endcase
    end

    // FSM, carry register and header-queue bookkeeping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            first_r     <= 1'b0;
            carry_r     <= {DATA_WD{1'b0}};
            carry_cnt_r <= {CNT_WD{1'b0}};
            count_r     <= {QCNT_WD{1'b0}};
            wr_ptr_r    <= {PTR_WD{1'b0}};
            rd_ptr_r    <= {PTR_WD{1'b0}};
        end else begin
            state_r     <= state_n;
            first_r     <= first_n;
            carry_r     <= carry_n;
            carry_cnt_r <= carry_cnt_n;
            count_r     <= count_r + {{(QCNT_WD-1){1'b0}}, push_s} - {{(QCNT_WD-1){1'b0}}, pop_s};
            wr_ptr_r    <= push_s ? wr_ptr_r + PTR_WD'(1) : wr_ptr_r;
            rd_ptr_r    <= pop_s ? rd_ptr_r + PTR_WD'(1) : rd_ptr_r;
        end
    end

    // Header storage; entries are only read while occupied, so no reset is needed.
    always_ff @(posedge clk) begin
        if (push_s) begin
            hdr_data_r[wr_ptr_r] <= hdr_word_s;
            hdr_cnt_r[wr_ptr_r]  <= hdr_cnt_s;
        end else begin
            hdr_data_r[wr_ptr_r] <= hdr_data_r[wr_ptr_r];
            hdr_cnt_r[wr_ptr_r]  <= hdr_cnt_r[wr_ptr_r];
        end
    end

    // Registered output stage; a drained beat is zeroed so idle outputs read as 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_out <= 1'b0;
            last_out  <= 1'b0;
            data_out  <= {DATA_WD{1'b0}};
            keep_out  <= {DATA_BYTE_WD{1'b0}};
        end else if (load_s) begin
            valid_out <= 1'b1;
            last_out  <= ld_last_s;
            data_out  <= ld_data_s;
            keep_out  <= ld_keep_s;
        end else if (ready_out) begin
            valid_out <= 1'b0;
            last_out  <= 1'b0;
            data_out  <= {DATA_WD{1'b0}};
            keep_out  <= {DATA_BYTE_WD{1'b0}};
        end else begin
            valid_out <= valid_out;
            last_out  <= last_out;
            data_out  <= data_out;
            keep_out  <= keep_out;
        end
    end
endmodule

// File: tb/tb_axis_hdr_insert_queued.sv
// Bench for axis_hdr_insert_queued: directed corner packets plus randomized traffic,
// scored against a byte-level model (header bytes then payload bytes, split into beats).
module tb_axis_hdr_insert_queued;
    localparam int LIM = 2000;

    typedef struct packed { logic [31:0] d; logic [3:0] k; logic l; } beat_t;
    typedef struct packed { logic [31:0] d; logic [2:0] c; } hdr_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid_insert = 1'b0;
    logic        ready_insert;
    logic [31:0] data_insert = 32'd0;
    logic [3:0]  keep_insert = 4'd0;
    logic [2:0]  byte_insert_cnt = 3'd0;
    logic        valid_in = 1'b0;
    logic        ready_in;
    logic        last_in = 1'b0;
    logic [31:0] data_in = 32'd0;
    logic [3:0]  keep_in = 4'd0;
    logic        valid_out;
    logic        ready_out = 1'b0;
    logic        last_out;
    logic [31:0] data_out;
    logic [3:0]  keep_out;
    logic [2:0]  hdr_count;

    int          n_cmp = 0;
    int          n_err = 0;
    int          ro_mode = 0;
    int          ro_ph = 0;
    bit          gaps = 1'b0;
    bit          hdr_busy = 1'b0;

    hdr_t        hq[$];
    beat_t       pq[$];
    logic [7:0]  exp_bytes[$];
    int          exp_len[$];
    int          cur_len = 0;
    int          consumed = 0;

    logic        hold_v = 1'b0;
    logic [31:0] hold_d;
    logic [3:0]  hold_k;
    logic        hold_l;

    axis_hdr_insert_queued #(.DATA_WD(32), .HDR_DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .valid_insert(valid_insert), .ready_insert(ready_insert),
        .data_insert(data_insert), .keep_insert(keep_insert), .byte_insert_cnt(byte_insert_cnt),
        .valid_in(valid_in), .ready_in(ready_in), .last_in(last_in),
        .data_in(data_in), .keep_in(keep_in),
        .valid_out(valid_out), .ready_out(ready_out), .last_out(last_out),
        .data_out(data_out), .keep_out(keep_out), .hdr_count(hdr_count)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic void add_header(input logic [31:0] w, input int c);
        int h;
        h = (c > 4) ? 4 : c;
        hq.push_back({w, 3'(c)});
        cur_len = h;
        for (int i = 0; i < h; i++) exp_bytes.push_back(8'(w >> (8 * (h - 1 - i))));
    endfunction

    function automatic void add_beat(input logic [31:0] d, input logic [3:0] k, input logic l);
        int n;
        n = l ? $countones(k) : 4;
        pq.push_back({d, (l ? k : 4'hF), l});
        for (int i = 0; i < n; i++) exp_bytes.push_back(8'(d >> (8 * (3 - i))));
        cur_len += n;
        if (l) exp_len.push_back(cur_len);
    endfunction

    task automatic add_rand_packet();
        int nb;
        int n;
        add_header($urandom, $urandom_range(0, 7));
        nb = $urandom_range(1, 4);
        for (int i = 0; i < nb - 1; i++) add_beat($urandom, 4'hF, 1'b0);
        n = $urandom_range(1, 4);
        add_beat($urandom, 4'(4'hF << (4 - n)), 1'b1);
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_beat(input beat_t b);
        int t;
        valid_in = 1'b1; data_in = b.d; keep_in = b.k; last_in = b.l;
        t = 0;
        @(negedge clk);
        while (!ready_in && t < LIM) begin
            t++;
            @(negedge clk);
        end
        check_val("ready_in_timeout", (t >= LIM), 1'b0);
        @(posedge clk);
        #1;
        valid_in = 1'b0; data_in = $urandom; keep_in = 4'h0; last_in = 1'b0;
    endtask

    task automatic drive_headers();
        hdr_t h;
        int t;
        hdr_busy = 1'b1;
        while (hq.size() != 0) begin
            h = hq.pop_front();
            if (gaps) wait_cyc($urandom_range(0, 2));
            valid_insert = 1'b1; data_insert = h.d; byte_insert_cnt = h.c; keep_insert = 4'($urandom);
            t = 0;
            @(negedge clk);
            while (!ready_insert && t < LIM) begin
                t++;
                @(negedge clk);
            end
            check_val("ready_insert_timeout", (t >= LIM), 1'b0);
            @(posedge clk);
            #1;
            valid_insert = 1'b0;
        end
        hdr_busy = 1'b0;
    endtask

    task automatic drive_payload();
        while (pq.size() != 0) begin
            if (gaps) wait_cyc($urandom_range(0, 2));
            send_beat(pq.pop_front());
        end
    endtask

    task automatic run_all();
        fork
            drive_headers();
            drive_payload();
        join
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (exp_len.size() != 0 && t < 5000) begin
            wait_cyc(1);
            t++;
        end
        check_val("drain_timeout", (t >= 5000), 1'b0);
    endtask

    task automatic consume_beat();
        int rem;
        int nb;
        logic [31:0] ed;
        logic [3:0] ek;
        if (exp_len.size() == 0) begin
            check_val("unexpected_beat", {keep_out, data_out}, 36'd0);
        end else begin
            rem = exp_len[0] - consumed;
            nb = (rem < 4) ? rem : 4;
            ed = 32'd0;
            ek = 4'd0;
            for (int i = 0; i < nb; i++) begin
                ed[31 - 8 * i -: 8] = exp_bytes.pop_front();
                ek[3 - i] = 1'b1;
            end
            check_val("out_data", data_out, ed);
            check_val("out_keep", keep_out, ek);
            check_val("out_last", last_out, (rem <= 4));
            if (rem <= 4) begin
                void'(exp_len.pop_front());
                consumed = 0;
            end else begin
                consumed += 4;
            end
        end
    endtask

    // Output scoreboard plus stall stability, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst) begin
            hold_v = 1'b0;
        end else begin
            if (hold_v) begin
                check_val("hold_valid", valid_out, 1'b1);
                check_val("hold_data", data_out, hold_d);
                check_val("hold_keep", keep_out, hold_k);
                check_val("hold_last", last_out, hold_l);
            end
            if (valid_out && !ready_out) begin
                check_val("stall_ready_in", ready_in, 1'b0);
                hold_v = 1'b1; hold_d = data_out; hold_k = keep_out; hold_l = last_out;
            end else begin
                hold_v = 1'b0;
            end
            if (valid_out && ready_out) consume_beat();
        end
    end

    // Downstream ready pattern: 0 always ready, 1 random, 2 periodic 3-cycle stall, else held low.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (ro_mode)
                0: ready_out = 1'b1;
                1: ready_out = ($urandom_range(0, 3) != 0);
                2: begin
                    ro_ph = ro_ph + 1;
                    ready_out = ((ro_ph % 8) >= 3);
                end
                default: ready_out = 1'b0;
            endcase
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        beat_t b;
        int t;

        rst = 1'b1;
        wait_cyc(3);
        check_val("rst_valid_out", valid_out, 1'b0);
        check_val("rst_last_out", last_out, 1'b0);
        check_val("rst_data_out", data_out, 32'd0);
        check_val("rst_keep_out", keep_out, 4'd0);
        check_val("rst_ready_in", ready_in, 1'b0);
        check_val("rst_hdr_count", hdr_count, 3'd0);
        check_val("rst_ready_insert", ready_insert, 1'b1);
        rst = 1'b0;
        wait_cyc(2);

        // Directed corner packets: H=2, H=3 with flush, H=4 standalone, clamped H.
        add_header(32'h0000AABB, 2);
        add_beat(32'h11223344, 4'hF, 1'b0);
        add_beat(32'h55667788, 4'hC, 1'b1);
        add_header(32'h00CCDDEE, 3);
        add_beat(32'h11223344, 4'hF, 1'b1);
        add_header(32'hDEADBEEF, 4);
        add_beat(32'h01234567, 4'hF, 1'b0);
        add_beat(32'h89ABCDEF, 4'h8, 1'b1);
        add_header(32'hCAFEF00D, 6);
        add_beat(32'h99AABBCC, 4'hE, 1'b1);
        run_all();
        drain();

        // H=0 passthrough at one-cycle latency; invalid bytes come out as zero.
        add_header(32'h12345678, 0);
        add_beat(32'h01020304, 4'hF, 1'b0);
        add_beat(32'h05060708, 4'h8, 1'b1);
        drive_headers();
        wait_cyc(2);
        send_beat(pq.pop_front());
        @(negedge clk);
        check_val("h0_valid1", valid_out, 1'b1);
        check_val("h0_data1", data_out, 32'h01020304);
        check_val("h0_last1", last_out, 1'b0);
        @(posedge clk);
        #1;
        send_beat(pq.pop_front());
        @(negedge clk);
        check_val("h0_valid2", valid_out, 1'b1);
        check_val("h0_data2", data_out, 32'h05000000);
        check_val("h0_keep2", keep_out, 4'h8);
        check_val("h0_last2", last_out, 1'b1);
        @(posedge clk);
        #1;
        drain();

        // Queue-full behaviour: five headers offered before any payload.
        for (int i = 0; i < 5; i++) begin
            add_header($urandom, 1);
            add_beat($urandom, 4'hF, 1'b1);
        end
        fork
            drive_headers();
        join_none
        wait_cyc(10);
        check_val("qfull_count", hdr_count, 3'd4);
        check_val("qfull_ready", ready_insert, 1'b0);
        send_beat(pq.pop_front());
        @(negedge clk);
        check_val("qpop_count", hdr_count, 3'd3);
        @(posedge clk);
        #1;
        t = 0;
        while (hdr_busy && t < 100) begin
            wait_cyc(1);
            t++;
        end
        check_val("q_fifth_accepted", hdr_busy, 1'b0);
        drive_payload();
        drain();

        // Periodic 3-cycle back-pressure.
        ro_mode = 2;
        for (int i = 0; i < 8; i++) add_rand_packet();
        run_all();
        drain();

        // Random traffic with random gaps and random back-pressure.
        ro_mode = 1;
        gaps = 1'b1;
        for (int i = 0; i < 30; i++) add_rand_packet();
        run_all();
        drain();
        check_val("idle_hdr_count", hdr_count, 3'd0);

        // Reset mid-packet with two headers still queued.
        gaps = 1'b0;
        ro_mode = 3;
        for (int i = 0; i < 3; i++) hq.push_back({32'h0000A1B2, 3'd2});
        drive_headers();
        wait_cyc(2);
        b = {32'h12345678, 4'hF, 1'b0};
        send_beat(b);
        wait_cyc(2);
        check_val("prerst_count", hdr_count, 3'd2);
        check_val("prerst_valid", valid_out, 1'b1);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check_val("mrst_valid_out", valid_out, 1'b0);
        check_val("mrst_last_out", last_out, 1'b0);
        check_val("mrst_data_out", data_out, 32'd0);
        check_val("mrst_keep_out", keep_out, 4'd0);
        check_val("mrst_ready_in", ready_in, 1'b0);
        check_val("mrst_hdr_count", hdr_count, 3'd0);
        check_val("mrst_ready_insert", ready_insert, 1'b1);
        exp_bytes.delete();
        exp_len.delete();
        consumed = 0;
        cur_len = 0;
        wait_cyc(2);
        rst = 1'b0;
        ro_mode = 1;
        wait_cyc(2);
        for (int i = 0; i < 4; i++) add_rand_packet();
        run_all();
        drain();
        check_val("final_hdr_count", hdr_count, 3'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
